// File: rtl/vcmp_mask_packer_if.sv
// rtl/vcmp_mask_packer_if.sv - compare-beat input and mask-word output bundle for vcmp_mask_packer
interface vcmp_mask_packer_if #(
  parameter int REQ_BE_WIDTH = 8,
  parameter int SEW_WIDTH    = 2,
  parameter int MASK_WIDTH   = 64
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [2:0]                    cmp_op;
  logic [SEW_WIDTH-1:0]          sew;
  logic [REQ_BE_WIDTH-1:0]       equal;
  logic [REQ_BE_WIDTH-1:0]       lt;
  logic                          out_valid;
  logic                          out_ready;
  logic [MASK_WIDTH-1:0]         out_mask;
  logic [$clog2(MASK_WIDTH):0]   out_count;
  logic                          out_last;
  logic                          sew_err;

  modport slave (
    input  in_valid, in_last, cmp_op, sew, equal, lt, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_last, sew_err
  );

  modport master (
    output in_valid, in_last, cmp_op, sew, equal, lt, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_last, sew_err
  );
endinterface

// File: rtl/vcmp_mask_packer.sv
// rtl/vcmp_mask_packer.sv - packs per-element vector compare results into MASK_WIDTH-bit mask words
module vcmp_mask_packer #(
  parameter int REQ_BE_WIDTH  = 8,
  parameter int SEW_WIDTH     = 2,
  parameter int MASK_WIDTH    = 64,
  parameter int ENABLE_64_BIT = 1
) (
  input logic               clk,
  input logic               rst,
  vcmp_mask_packer_if.slave bus
);
  localparam int CNT_W = $clog2(MASK_WIDTH) + 1;

  logic [MASK_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic [SEW_WIDTH-1:0]  word_sew_q, word_sew_d;
  logic                  out_valid_q, out_valid_d;
  logic [MASK_WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_W-1:0]      out_count_q, out_count_d;
  logic                  out_last_q, out_last_d;
  logic                  sew_err_q, sew_err_d;

  logic [SEW_WIDTH-1:0]    sew_eff;
  logic [CNT_W-1:0]        n_elem;
  logic [REQ_BE_WIDTH-1:0] beat_bits;
  logic [MASK_WIDTH-1:0]   merged;
  logic [CNT_W-1:0]        fill_sum;
  logic                    in_ready;
  logic                    accept;
  logic                    mismatch;
  logic                    close;

  assign in_ready     = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    sew_eff = bus.sew;
    if (ENABLE_64_BIT == 0 && bus.sew == SEW_WIDTH'(3)) begin
      sew_eff = SEW_WIDTH'(2);
    end
  end

  assign n_elem = CNT_W'(REQ_BE_WIDTH >> sew_eff);

  // Lanes at or above n_elem belong to no element and are forced to zero.
  always_comb begin
    beat_bits = '0;
    for (int k = 0; k < REQ_BE_WIDTH; k++) begin
      if (k < int'(n_elem)) begin
        case (bus.cmp_op)
          3'd0:    beat_bits[k] = bus.equal[k];
          3'd1:    beat_bits[k] = ~bus.equal[k];
          3'd2:    beat_bits[k] = bus.lt[k];
          3'd3:    beat_bits[k] = bus.lt[k] | bus.equal[k];
          3'd4:    beat_bits[k] = ~bus.lt[k] & ~bus.equal[k];
          3'd5:    beat_bits[k] = ~bus.lt[k];
          default: beat_bits[k] = 1'b0;
        endcase
      end
    end
  end

  assign merged   = acc_q | (MASK_WIDTH'(beat_bits) << fill_q);
  assign fill_sum = fill_q + n_elem;
  assign accept   = bus.in_valid & in_ready;
  assign mismatch = (fill_q != '0) && (sew_eff != word_sew_q);
  // A discarded beat only closes through in_last; fill is nonzero there, so no empty word.
  assign close    = accept && (mismatch ? bus.in_last
                                        : (bus.in_last || fill_sum == CNT_W'(MASK_WIDTH)));

  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    word_sew_d  = word_sew_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    sew_err_d   = sew_err_q;

    if (accept && fill_q == '0) begin
      word_sew_d = sew_eff;
    end
    if (accept && mismatch) begin
      sew_err_d = 1'b1;
    end

    if (close) begin
      out_valid_d = 1'b1;
      out_mask_d  = mismatch ? acc_q : merged;
      out_count_d = mismatch ? fill_q : fill_sum;
      out_last_d  = bus.in_last;
      acc_d       = '0;
      fill_d      = '0;
    end else begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept && !mismatch) begin
        acc_d  = merged;
        fill_d = fill_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      fill_q      <= '0;
      word_sew_q  <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      sew_err_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      word_sew_q  <= word_sew_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      sew_err_q   <= sew_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
  assign bus.sew_err   = sew_err_q;
endmodule
